spi_write_arbiter: RTL and testbench

Shares one SPI serializer between NUM_REQ independent register-write requesters. It selects a requester round-robin and latches its word. It then issues a one-cycle load to the serializer and tracks the frame through the serializer's busy indication. After each frame it enforces a minimum chip-select gap before the next grant. It sits between the configuration clients (PLL, attenuator, DAC setup logic) and the SPI serializer.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 59 +++++
 rtl/spi_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_spi_write_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI write arbiter: controller state
//               encoding and the default serializer word width.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

   localparam int STATE_BitC         = 3;
   localparam int DEF_REGISTER_WIDTH = 32;

   typedef enum logic [STATE_BitC-1:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      GAP        = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin request selector. Searches last+1, last+2, ...
//               modulo NUM_REQ and returns the first requester found as a
//               one-hot grant and an index. The pointer moves only when the
//               caller accepts the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               valid
);

   logic [IDX_W-1:0] r_last;
   int               w_cand;
   logic [IDX_W-1:0] w_cidx;

   // Walk from the farthest candidate to the nearest so the nearest set request wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      w_cand    = 0;
      w_cidx    = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         w_cand = int'(r_last) + i;
         if (w_cand >= NUM_REQ) begin
            w_cand = w_cand - NUM_REQ;
         end
         w_cidx = IDX_W'(w_cand);
         if (req[w_cidx]) begin
            grant         = '0;
            grant[w_cidx] = 1'b1;
            grant_idx     = w_cidx;
            valid         = 1'b1;
         end
      end
   end

   // Pointer starts at the top index so requester 0 has first priority after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= IDX_W'(NUM_REQ - 1);
      end else if (advance && valid) begin
         r_last <= grant_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_write_arbiter
// Description : Shares one SPI serializer between NUM_REQ register-write
//               requesters. Grants round-robin, latches the word, strobes the
//               serializer, follows its busy flag (with a start timeout) and
//               enforces a chip-select gap before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_write_arbiter
   import spi_pkg::*;
#(
   parameter  int Register_Width = DEF_REGISTER_WIDTH,
   parameter  int NUM_REQ        = 4,
   parameter  int GAP_CYCLES     = 16,
   parameter  int START_TIMEOUT  = 8,
   localparam int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ*Register_Width-1:0] req_data,
   output logic [NUM_REQ-1:0]                ack,
   output logic                              err_timeout,
   output logic [Register_Width-1:0]         ser_data,
   output logic                              ser_ld,
   input  logic                              ser_busy,
   output logic [ID_W-1:0]                   active_id,
   output logic                              busy_o
);

   localparam int c_CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [c_CNT_W-1:0]          r_cnt;
   logic [c_CNT_W-1:0]          w_cnt_nxt;
   logic [Register_Width-1:0]   r_ser_data;
   logic [ID_W-1:0]             r_active_id;
   logic [NUM_REQ-1:0]          r_active_oh;
   logic                        r_busy;

   logic                        w_take;
   logic                        w_done;
   logic                        w_err;
   logic                        w_gap_end;
   logic                        w_ld;
   logic [NUM_REQ-1:0]          w_grant;
   logic [ID_W-1:0]             w_grant_idx;
   logic                        w_grant_vld;
   logic [Register_Width-1:0]   w_sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .advance   (w_take),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .valid     (w_grant_vld)
   );

   // Pick the granted requester's word out of the flat data bus.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_idx == ID_W'(i)) begin
            w_sel_data = req_data[i*Register_Width +: Register_Width];
         end
      end
   end

   // Next-state and strobe decode; one counter is shared by the start timeout and the gap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take      = 1'b0;
      w_ld        = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_gap_end   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_grant_vld) begin
               w_take      = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_ld        = 1'b1;
            w_cnt_nxt   = c_CNT_W'(START_TIMEOUT);
            w_state_nxt = WAIT_START;
         end
         WAIT_START: begin
            if (ser_busy) begin
               w_state_nxt = WAIT_DONE;
            end else if (r_cnt <= c_CNT_W'(1)) begin
               // Serializer never raised busy: finish the request with an error.
               w_done      = 1'b1;
               w_err       = 1'b1;
               w_cnt_nxt   = c_CNT_W'(GAP_CYCLES);
               w_state_nxt = GAP;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!ser_busy) begin
               w_done      = 1'b1;
               w_cnt_nxt   = c_CNT_W'(GAP_CYCLES);
               w_state_nxt = GAP;
            end
         end
         GAP: begin
            if (r_cnt <= c_CNT_W'(1)) begin
               w_gap_end   = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Grant-time capture of word and owner; busy spans grant through end of gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ser_data  <= '0;
         r_active_id <= '0;
         r_active_oh <= '0;
         r_busy      <= 1'b0;
      end else if (w_take) begin
         r_ser_data  <= w_sel_data;
         r_active_id <= w_grant_idx;
         r_active_oh <= w_grant;
         r_busy      <= 1'b1;
      end else if (w_gap_end) begin
         r_busy      <= 1'b0;
      end
   end

   assign ser_ld      = w_ld;
   assign ack         = w_done ? r_active_oh : '0;
   assign err_timeout = w_err;
   assign ser_data    = r_ser_data;
   assign active_id   = r_active_id;
   assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_write_arbiter
// Description : Self-checking bench for spi_write_arbiter. A timestamp-based
//               model predicts strobes, acks and held values every cycle; a
//               set of hand-computed literals pins ordering and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_write_arbiter;

   localparam int W = 32;
   localparam int N = 4;
   localparam int G = 16;
   localparam int T = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   ack;
   logic           err_timeout;
   logic [W-1:0]   ser_data;
   logic           ser_ld;
   logic           ser_busy;
   logic [1:0]     active_id;
   logic           busy_o;

   always #5 clk = ~clk;

   spi_write_arbiter #(
      .Register_Width (W),
      .NUM_REQ        (N),
      .GAP_CYCLES     (G),
      .START_TIMEOUT  (T)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .err_timeout (err_timeout),
      .ser_data    (ser_data),
      .ser_ld      (ser_ld),
      .ser_busy    (ser_busy),
      .active_id   (active_id),
      .busy_o      (busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model: one outstanding frame described by timestamps
   bit           m_busy, m_started, m_acked;
   int           m_id, m_last, m_ld_cyc, m_idle_cyc;
   logic [W-1:0] m_data;

   // serializer stand-in and requester behaviour
   int           win_from = -1, win_to = -2, sb_delay = 2, sb_len = 4;
   bit           sb_dead = 0, sb_stray = 0;
   logic [N-1:0] keep = '0, drop_mask = '0;

   int           ld_cyc_q[$], ld_id_q[$], ack_cyc_q[$], ack_id_q[$];
   bit           ack_err_q[$];
   logic [W-1:0] ld_data_q[$], ack_data_q[$];

   int           req_cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_started = 0; m_acked = 0;
      m_id = 0; m_last = N - 1; m_ld_cyc = -100; m_idle_cyc = -1; m_data = '0;
   endtask

   task automatic eval_cycle();
      logic [N-1:0] exp_ack;
      logic         exp_ld, exp_err;
      int           c, id;
      if (rst) begin
         model_reset();
         win_from = -1; win_to = -2; drop_mask = '0;
         chk("rst_ack", ack, 0);
         chk("rst_err", err_timeout, 0);
         chk("rst_ld", ser_ld, 0);
         chk("rst_busy_o", busy_o, 0);
         chk("rst_active_id", active_id, 0);
         chk("rst_ser_data", ser_data, 0);
         return;
      end
      if (m_busy && cyc == m_idle_cyc) m_busy = 0;
      exp_ld  = m_busy && (cyc == m_ld_cyc);
      exp_ack = '0;
      exp_err = 0;
      if (m_busy && !m_acked && cyc > m_ld_cyc) begin
         if (ser_busy) m_started = 1;
         else if (m_started || cyc == m_ld_cyc + T) begin
            exp_ack[m_id] = 1'b1;
            exp_err       = !m_started;
            m_acked       = 1;
            m_idle_cyc    = cyc + G + 1;
         end
      end
      chk("ser_ld", ser_ld, exp_ld);
      chk("ack", ack, exp_ack);
      chk("err_timeout", err_timeout, exp_err);
      chk("busy_o", busy_o, m_busy);
      if (m_busy) begin
         chk("active_id", active_id, m_id);
         chk("ser_data", ser_data, m_data);
      end
      if (ser_ld) begin
         ld_cyc_q.push_back(cyc); ld_id_q.push_back(int'(active_id)); ld_data_q.push_back(ser_data);
      end
      if (ack != 0) begin
         id = 0;
         for (int k = 0; k < N; k++) if (ack[k]) id = k;
         ack_cyc_q.push_back(cyc); ack_id_q.push_back(id);
         ack_err_q.push_back(err_timeout); ack_data_q.push_back(ser_data);
      end
      if (!m_busy) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (req[c]) begin
               m_busy = 1; m_id = c; m_last = c; m_data = req_data[c*W +: W];
               m_ld_cyc = cyc + 1; m_started = 0; m_acked = 0; m_idle_cyc = -1;
               break;
            end
         end
      end
      if (ser_ld && !sb_dead) begin
         win_from = cyc + sb_delay;
         win_to   = win_from + sb_len - 1;
      end
      drop_mask = ack & ~keep;
   endtask

   task automatic step();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      cyc++;
      #1;
      ser_busy  = sb_stray || (cyc >= win_from && cyc <= win_to);
      req       = req & ~drop_mask;
      drop_mask = '0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic request(input int i, input logic [W-1:0] d);
      req_data[i*W +: W] = d;
      req[i] = 1'b1;
   endtask

   task automatic clear_logs();
      ld_cyc_q.delete(); ld_id_q.delete(); ld_data_q.delete();
      ack_cyc_q.delete(); ack_id_q.delete(); ack_err_q.delete(); ack_data_q.delete();
   endtask

   task automatic wait_lds(input int n, input string name);
      int g = 0;
      while (ld_cyc_q.size() < n && g < 2000) begin step(); g++; end
      chk(name, ld_cyc_q.size() >= n, 1);
   endtask

   task automatic wait_acks(input int n, input string name);
      int g = 0;
      while (ack_cyc_q.size() < n && g < 2000) begin step(); g++; end
      chk(name, ack_cyc_q.size() >= n, 1);
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while ((req != 0 || busy_o) && g < 2000) begin step(); g++; end
      chk(name, (req == 0) && !busy_o, 1);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      steps(3);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = '0; req_data = '0; ser_busy = 1'b0;
      model_reset();
      steps(3);
      rst = 1'b0;

      // stray serializer activity while idle must be ignored
      sb_stray = 1; steps(4); sb_stray = 0; steps(2);

      // single request: ld in the cycle after the grant cycle, ack when busy falls
      clear_logs();
      sb_delay = 3; sb_len = 10;
      request(0, 32'hA5A5_1234);
      req_cyc = cyc;
      wait_acks(1, "t1_ack_wait");
      chk("t1_ld_latency", ld_cyc_q[0] - req_cyc, 1);
      chk("t1_ld_data", ld_data_q[0], 32'hA5A5_1234);
      chk("t1_ack_after_ld", ack_cyc_q[0] - ld_cyc_q[0], 13);
      chk("t1_ack_id", ack_id_q[0], 0);
      chk("t1_no_err", ack_err_q[0], 0);
      wait_idle("t1_idle");

      // all four requesting after reset: order 0,1,2,3,0 with fixed spacing
      reset_dut();
      clear_logs();
      sb_delay = 2; sb_len = 5;
      keep = 4'b1111;
      for (int i = 0; i < N; i++) request(i, 32'h1000_0000 + i);
      wait_lds(5, "t2_ld_wait");
      keep = '0;
      chk("t2_order0", ld_id_q[0], 0);
      chk("t2_order1", ld_id_q[1], 1);
      chk("t2_order2", ld_id_q[2], 2);
      chk("t2_order3", ld_id_q[3], 3);
      chk("t2_order4", ld_id_q[4], 0);
      for (int k = 0; k < 4; k++) chk("t2_ld_spacing", ld_cyc_q[k+1] - ld_cyc_q[k], 2 + 5 + G + 2);
      wait_idle("t2_idle");

      // requester 2 keeps re-requesting while 1 waits: strict alternation
      clear_logs();
      keep = 4'b0110;
      request(2, 32'h2222_0002);
      wait_lds(1, "t3_first_ld");
      request(1, 32'h1111_0001);
      wait_lds(4, "t3_ld_wait");
      keep = '0;
      chk("t3_order0", ld_id_q[0], 2);
      chk("t3_order1", ld_id_q[1], 1);
      chk("t3_order2", ld_id_q[2], 2);
      chk("t3_order3", ld_id_q[3], 1);
      wait_idle("t3_idle");

      // dead serializer: timeout ack T cycles after LOAD, then gap, then next grant
      clear_logs();
      sb_dead = 1;
      request(3, 32'hDEAD_0003);
      wait_acks(1, "t4_ack_wait");
      sb_dead = 0; sb_delay = 1; sb_len = 2;
      request(0, 32'h0BAD_0000);
      chk("t4_timeout_latency", ack_cyc_q[0] - ld_cyc_q[0], T);
      chk("t4_err", ack_err_q[0], 1);
      chk("t4_ack_id", ack_id_q[0], 3);
      wait_lds(2, "t4_next_ld");
      chk("t4_gap_to_ld", ld_cyc_q[1] - ack_cyc_q[0], G + 2);
      chk("t4_next_id", ld_id_q[1], 0);
      wait_idle("t4_idle");

      // reset during WAIT_DONE: no ack, arbitration restarts from requester 0
      clear_logs();
      sb_delay = 1; sb_len = 40;
      request(1, 32'hCAFE_0001);
      wait_lds(1, "t5_ld_wait");
      steps(5);
      request(2, 32'hCAFE_0002);
      rst = 1'b1;
      steps(3);
      sb_len = 6;
      rst = 1'b0;
      chk("t5_no_ack", ack_cyc_q.size(), 0);
      wait_lds(3, "t5_regrant");
      chk("t5_regrant_first", ld_id_q[1], 1);
      chk("t5_regrant_second", ld_id_q[2], 2);
      wait_idle("t5_idle");

      // data changed during LOAD: the latched word holds through the frame
      clear_logs();
      sb_delay = 2; sb_len = 4;
      request(0, 32'h1111_2222);
      begin
         int g = 0;
         while (!busy_o && g < 20) begin step(); g++; end
      end
      req_data[0 +: W] = 32'hFFFF_0000;
      wait_acks(1, "t6_ack_wait");
      chk("t6_held_data", ack_data_q[0], 32'h1111_2222);
      wait_idle("t6_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
